// File: rtl/lsq_serial_mem.sv
// lsq_serial_mem: in-order load/store queue feeding a byte-serial RAM/IO port.
module lsq_serial_mem #(
  parameter int          LSB_SIZE  = 8,
  parameter int          LSB_WIDTH = 3,
  parameter int          ROB_WIDTH = 4,
  parameter int          SLACK     = 3,
  parameter logic [31:0] IO_BASE   = 32'h30000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 alloc_valid,
  input  logic [ROB_WIDTH-1:0] alloc_tag,
  input  logic                 rs_valid,
  input  logic [2:0]           rs_op,
  input  logic [ROB_WIDTH-1:0] rs_tag,
  input  logic [31:0]          rs_addr,
  input  logic [31:0]          rs_wdata,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_tag,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  output logic                 alloc_ok,
  output logic                 wb_valid,
  output logic [ROB_WIDTH-1:0] wb_tag,
  output logic [31:0]          wb_data
);
  localparam int CW = LSB_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;
  state_t r_state, w_state_next;
  logic [LSB_SIZE-1:0]  r_valid, r_ready, r_commit, w_keep_mask;
  logic [ROB_WIDTH-1:0] r_tag [LSB_SIZE];
  logic [2:0]           r_op [LSB_SIZE];
  logic [31:0]          r_addr [LSB_SIZE];
  logic [31:0]          r_wdata [LSB_SIZE];
  logic [LSB_WIDTH-1:0] r_head, r_tail;
  logic [CW-1:0]        r_count, w_keep, w_count_next;
  logic [2:0]           r_k, w_n, w_op;
  logic [23:0]          r_data;
  logic [31:0]          w_raw, w_ld;
  logic w_is_load, w_start, w_ld_done, w_st_done, w_retire, w_alloc;
  assign w_op      = r_op[r_head];
  assign w_is_load = w_op < 3'd5;
  assign w_n       = (w_op == 3'd0 || w_op == 3'd1 || w_op == 3'd5) ? 3'd1 :
                     (w_op == 3'd2 || w_op == 3'd3 || w_op == 3'd6) ? 3'd2 : 3'd4;
  // Speculative only for plain-RAM loads; stores and IO loads wait for commit.
  assign w_start   = r_state == IDLE && !clear && r_valid[r_head] && r_ready[r_head] &&
                     (r_commit[r_head] || (w_is_load && r_addr[r_head] < IO_BASE));
  assign w_ld_done = r_state == LOAD && r_k == w_n;
  assign w_st_done = r_state == STORE && r_k == w_n - 3'd1;
  assign w_retire  = w_st_done || (w_ld_done && !clear);
  assign w_alloc   = alloc_valid && !clear && r_count != CW'(LSB_SIZE);
  // Bytes shift in from the top, so the last byte comes straight from mem_din.
  assign w_raw = {mem_din, r_data} >> {3'd4 - w_n, 3'b000};
  assign w_ld  = w_op[2] ? w_raw :
                 w_op[1] ? {{16{w_raw[15] & ~w_op[0]}}, w_raw[15:0]} :
                           {{24{w_raw[7] & ~w_op[0]}}, w_raw[7:0]};
  assign w_count_next = clear ? w_keep - CW'(w_retire) : r_count + CW'(w_alloc) - CW'(w_retire);
  // Committed run starting at head survives a clear.
  always_comb begin : scan
    logic                 run;
    logic [LSB_WIDTH-1:0] idx;
    run = 1'b1;
    idx = '0;
    w_keep = '0;
    w_keep_mask = '0;
    for (int i = 0; i < LSB_SIZE; i++) begin
      idx = r_head + LSB_WIDTH'(i);
      run = run & r_valid[idx] & r_commit[idx];
      w_keep_mask[idx] = run;
      w_keep = w_keep + CW'(run);
    end
  end
  always_comb begin
    w_state_next = r_state;
    if (w_start) w_state_next = w_is_load ? LOAD : STORE;
    else if ((r_state == LOAD && clear) || w_ld_done || w_st_done) w_state_next = IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else if (rdy_in) r_state <= w_state_next;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_ready  <= '0;
      r_commit <= '0;
      r_k      <= '0;
      r_data   <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
      alloc_ok <= 1'b1;
    end else if (rdy_in) begin
      r_count  <= w_count_next;
      alloc_ok <= CW'(LSB_SIZE) - w_count_next > CW'(SLACK);
      mem_wr   <= w_state_next == STORE;
      wb_valid <= w_ld_done && !clear;
      r_k      <= w_start ? 3'd0 : r_k + 3'd1;
      if (w_start) begin
        mem_a    <= r_addr[r_head];
        mem_dout <= r_wdata[r_head][7:0];
      end else if (r_state != IDLE && r_k < w_n - 3'd1) begin
        mem_a    <= mem_a + 32'd1;
        mem_dout <= 8'(r_wdata[r_head] >> {r_k + 3'd1, 3'b000});
      end
      if (r_state == LOAD && r_k != 3'd0) r_data <= {mem_din, r_data[23:8]};
      if (w_ld_done) begin
        wb_tag  <= r_tag[r_head];
        wb_data <= w_ld;
      end
      if (clear) begin
        r_valid <= r_valid & w_keep_mask;
        r_tail  <= r_head + w_keep[LSB_WIDTH-1:0];
      end else begin
        for (int i = 0; i < LSB_SIZE; i++) begin
          if (rs_valid && r_valid[i] && r_tag[i] == rs_tag) begin
            r_ready[i] <= 1'b1;
            r_op[i]    <= rs_op;
            r_addr[i]  <= rs_addr;
            r_wdata[i] <= rs_wdata;
          end
          if (commit_valid && r_valid[i] && r_tag[i] == commit_tag) r_commit[i] <= 1'b1;
        end
        if (w_alloc) begin
          r_valid[r_tail]  <= 1'b1;
          r_ready[r_tail]  <= 1'b0;
          r_commit[r_tail] <= 1'b0;
          r_tag[r_tail]    <= alloc_tag;
          r_tail           <= r_tail + LSB_WIDTH'(1);
        end
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + LSB_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_lsq_serial_mem.sv
// tb_lsq_serial_mem: directed and randomized checks of lsq_serial_mem against a byte-memory model.
module tb_lsq_serial_mem;
  logic        clk_in = 0, rst_in = 1, rdy_in = 1, clear = 0;
  logic        alloc_valid = 0, rs_valid = 0, commit_valid = 0;
  logic [3:0]  alloc_tag = 0, rs_tag = 0, commit_tag = 0;
  logic [2:0]  rs_op = 0;
  logic [31:0] rs_addr = 0, rs_wdata = 0;
  logic [7:0]  mem_din = 0, mem_dout;
  logic [31:0] mem_a, wb_data;
  logic        mem_wr, alloc_ok, wb_valid;
  logic [3:0]  wb_tag;
  int vectors = 0, miscompares = 0;
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [35:0] wb_q [$];
  logic [39:0] wr_q [$];

  always #5 clk_in = ~clk_in;

  lsq_serial_mem dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .rs_valid(rs_valid), .rs_op(rs_op), .rs_tag(rs_tag), .rs_addr(rs_addr), .rs_wdata(rs_wdata),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .alloc_ok(alloc_ok), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(posedge clk_in) if (rdy_in) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : dflt(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  always @(negedge clk_in) if (rdy_in && !rst_in) begin
    if (wb_valid) wb_q.push_back({wb_tag, wb_data});
    if (mem_wr) wr_q.push_back({mem_a, mem_dout});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mget(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic int nbytes(input logic [2:0] op);
    return (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
  endfunction
  function automatic logic [31:0] ld_exp(input logic [2:0] op, input logic [31:0] a);
    longint v = 0;
    int n = nbytes(op);
    for (int k = 0; k < n; k++) v += longint'(mget(a + 32'(k))) << (8 * k);
    if ((op == 0 || op == 2) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask
  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask
  task automatic do_alloc(input logic [3:0] t);
    alloc_valid = 1; alloc_tag = t; tick(); alloc_valid = 0;
  endtask
  task automatic do_rs(input logic [3:0] t, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    rs_valid = 1; rs_tag = t; rs_op = op; rs_addr = a; rs_wdata = d; tick(); rs_valid = 0;
  endtask
  task automatic do_commit(input logic [3:0] t);
    commit_valid = 1; commit_tag = t; tick(); commit_valid = 0;
  endtask
  task automatic wait_wb(output int lat);
    lat = 0;
    while (!wb_valid && lat < 60) begin tick(); lat++; end
  endtask
  task automatic wait_q_wb(input int n);
    int c = 0;
    while (wb_q.size() < n && c < 400) begin tick(); c++; end
    chk("wb_queue_count", 64'(wb_q.size()), 64'(n));
  endtask
  task automatic wait_q_wr(input int n);
    int c = 0;
    while (wr_q.size() < n && c < 100) begin tick(); c++; end
    chk("wr_queue_count", 64'(wr_q.size()), 64'(n));
  endtask
  task automatic check_writes(input string name, input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k < n && k < wr_q.size(); k++) begin
      chk(name, 64'(wr_q[k]), 64'({a + 32'(k), 8'(d >> (8 * k))}));
      ref_mem[a + 32'(k)] = 8'(d >> (8 * k));
    end
    wr_q.delete();
  endtask
  task automatic load_check(input string name, input logic [3:0] t, input logic [2:0] op, input logic [31:0] a);
    int lat;
    do_alloc(t);
    do_rs(t, op, a, 32'h0);
    wait_wb(lat);
    chk({name, "_lat"}, 64'(lat), 64'(nbytes(op) + 2));
    chk({name, "_tag"}, 64'(wb_tag), 64'(t));
    chk({name, "_data"}, 64'(wb_data), 64'(ld_exp(op, a)));
    tick();
    chk({name, "_pulse"}, 64'(wb_valid), 64'(0));
  endtask

  initial begin
    int lat, act;
    logic [31:0] a0, a, d;
    logic [2:0]  op;
    logic [2:0]  f_op [8];
    logic [31:0] f_a [8];
    logic [3:0]  t;
    logic        io;
    repeat (3) tick();
    chk("rst_mem_wr", 64'(mem_wr), 64'(0));
    chk("rst_mem_a", 64'(mem_a), 64'(0));
    chk("rst_mem_dout", 64'(mem_dout), 64'(0));
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_alloc_ok", 64'(alloc_ok), 64'(1));
    rst_in = 0;
    tick();
    // word load latency and byte order
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    load_check("t1_lw", 4'd3, 3'd4, 32'h100);
    chk("t1_const", 64'(wb_data), 64'(32'h44332211));
    // sign/zero extension
    poke(32'h10, 8'h80);
    load_check("t2_lb", 4'd1, 3'd0, 32'h10);
    chk("t2_lb_const", 64'(wb_data), 64'(32'hFFFFFF80));
    load_check("t2_lbu", 4'd2, 3'd1, 32'h10);
    chk("t2_lbu_const", 64'(wb_data), 64'(32'h00000080));
    poke(32'h20, 8'h34); poke(32'h21, 8'h92);
    load_check("t2_lh", 4'd3, 3'd2, 32'h20);
    chk("t2_lh_const", 64'(wb_data), 64'(32'hFFFF9234));
    load_check("t2_lhu", 4'd4, 3'd3, 32'h20);
    // store waits for commit
    wr_q.delete();
    do_alloc(4'd5);
    do_rs(4'd5, 3'd7, 32'h200, 32'hDEADBEEF);
    act = 0;
    repeat (20) begin tick(); act += int'(mem_wr); end
    chk("t3_no_write", 64'(act), 64'(0));
    do_commit(4'd5);
    wait_q_wr(4);
    check_writes("t3_sw_byte", 32'h200, 32'hDEADBEEF, 4);
    chk("t3_ram_word", 64'({ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]}), 64'(32'hDEADBEEF));
    // IO load waits for commit
    tick();
    a0 = mem_a;
    do_alloc(4'd6);
    do_rs(4'd6, 3'd4, 32'h30004, 32'h0);
    act = 0;
    repeat (10) begin tick(); act += int'(wb_valid) + int'(mem_wr) + int'(mem_a != a0); end
    chk("t4_no_activity", 64'(act), 64'(0));
    do_commit(4'd6);
    wait_wb(lat);
    chk("t4_lat", 64'(lat), 64'(6));
    chk("t4_data", 64'(wb_data), 64'(ld_exp(3'd4, 32'h30004)));
    tick();
    // clear during a committed store
    wr_q.delete(); wb_q.delete();
    do_alloc(4'd1); do_alloc(4'd2); do_alloc(4'd3);
    do_rs(4'd2, 3'd4, 32'h40, 32'h0);
    do_rs(4'd3, 3'd5, 32'h50, 32'h77);
    do_rs(4'd1, 3'd7, 32'h300, 32'hCAFEF00D);
    do_commit(4'd1);
    tick(); tick();
    chk("t5_mid_write", 64'(mem_wr), 64'(1));
    clear = 1; tick(); clear = 0;
    chk("t5_write_continues", 64'(mem_wr), 64'(1));
    do_commit(4'd3);
    repeat (15) tick();
    chk("t5_write_count", 64'(wr_q.size()), 64'(4));
    check_writes("t5_sw_byte", 32'h300, 32'hCAFEF00D, 4);
    chk("t5_no_wb", 64'(wb_q.size()), 64'(0));
    chk("t5_alloc_ok", 64'(alloc_ok), 64'(1));
    // fill, overflow, drain
    wb_q.delete();
    for (int k = 0; k < 8; k++) begin
      do_alloc(4'(k));
      chk("t6_alloc_ok", 64'(alloc_ok), 64'((8 - (k + 1)) > 3));
    end
    do_alloc(4'd8);
    chk("t6_full_alloc_ok", 64'(alloc_ok), 64'(0));
    for (int k = 0; k < 8; k++) begin
      f_op[k] = 3'($urandom_range(0, 4));
      f_a[k] = 32'h500 + 32'($urandom_range(0, 63));
      do_rs(4'(k), f_op[k], f_a[k], 32'h0);
    end
    do_rs(4'd8, 3'd4, 32'h0, 32'h0);
    wait_q_wb(8);
    repeat (10) tick();
    chk("t6_wb_total", 64'(wb_q.size()), 64'(8));
    for (int k = 0; k < 8 && wb_q.size() > 0; k++) begin
      chk("t6_wb", 64'(wb_q.pop_front()), 64'({4'(k), ld_exp(f_op[k], f_a[k])}));
    end
    chk("t6_empty_alloc_ok", 64'(alloc_ok), 64'(1));
    // pause mid-load
    do_alloc(4'd9);
    do_rs(4'd9, 3'd4, 32'h600, 32'h0);
    tick(); tick();
    a0 = mem_a;
    rdy_in = 0;
    repeat (4) tick();
    chk("rdy_frozen_a", 64'(mem_a), 64'(a0));
    chk("rdy_frozen_wb", 64'(wb_valid), 64'(0));
    rdy_in = 1;
    wait_wb(lat);
    chk("rdy_lat", 64'(lat), 64'(4));
    chk("rdy_data", 64'(wb_data), 64'(ld_exp(3'd4, 32'h600)));
    tick();
    // random mixed traffic, one op at a time
    wb_q.delete(); wr_q.delete();
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      io = op < 5 && $urandom_range(0, 3) == 0;
      a  = io ? 32'h30000 + 32'($urandom_range(0, 15)) : 32'h400 + 32'($urandom_range(0, 31));
      d  = $urandom;
      t  = 4'(i + 10);
      do_alloc(t);
      do_rs(t, op, a, d);
      if (op >= 5 || io) begin
        repeat ($urandom_range(0, 3)) tick();
        if (io) chk("rnd_io_hold", 64'(wb_q.size()), 64'(0));
        do_commit(t);
      end
      if (op < 5) begin
        wait_q_wb(1);
        if (wb_q.size() > 0) chk("rnd_load", 64'(wb_q.pop_front()), 64'({t, ld_exp(op, a)}));
        wb_q.delete();
      end else begin
        wait_q_wr(nbytes(op));
        check_writes("rnd_store_byte", a, d, nbytes(op));
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
